inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//   Instruction fetch front end: the initiator side of the instruction-memory
//   read interface. It holds the PC and drives word-aligned addresses to the
//   combinational instruction memory. Returned words go into a small FIFO, which
//   feeds decode through a valid/ready handshake.
//   Branch/jump resolution in later stages redirects the PC and flushes the FIFO.
// PARAMETERS
//   RESET_PC   32'h0  PC value loaded on reset (low 2 bits ignored)
//   BUF_DEPTH  2      instruction FIFO entries (power of 2, >=2)
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   reset, asynchronous, active-low
//   imem_addr       out  32  fetch byte address to instruction memory, always [1:0]=0
//   imem_data       in   32  instruction word, valid same cycle as imem_addr (combinational memory)
//   redirect_valid  in   1   redirect request from branch/jump resolution
//   redirect_pc     in   32  redirect target byte address
//   inst_valid      out  1   FIFO head holds a valid instruction
//   inst            out  32  FIFO head instruction word
//   inst_pc         out  32  byte address the head instruction was fetched from
//   inst_ready      in   1   decode accepts head this cycle
//   buf_count       out  $clog2(BUF_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//   Reset (rst=0, async): pc=RESET_PC&~3, FIFO empty, buf_count=0, inst_valid=0,
//     inst=0, inst_pc=0. imem_addr=pc, combinational.
//   pop  = inst_valid & inst_ready.
//   push = ~redirect_valid & (buf_count<BUF_DEPTH | pop).
//     A full FIFO fetches the next word in the same cycle it pops.
//   push: FIFO tail <= {pc, imem_data}; pc <= pc+4, modulo 2^32
//     (0xFFFFFFFC wraps to 0x0).
//   No push: pc holds; imem_addr is stable while decode stalls.
//   redirect_valid=1 overrides everything:
//     - FIFO cleared at the edge; buf_count=0 next cycle.
//     - pc <= redirect_pc & ~3; the word on imem_data that cycle is discarded.
//     - A pop asserted in the same cycle is also discarded; decode flushes its own copy.
//   Latency: word addressed in cycle N shows at FIFO head in cycle N+1 if the FIFO
//     was empty. After reset release or redirect, inst_valid rises 1 cycle later.
//     Steady state with inst_ready=1: 1 instruction per cycle, no bubbles.
//   inst/inst_pc come from registered FIFO storage (head pointer), not from imem_data.
//     When empty, inst_valid=0 and inst/inst_pc hold their last value.
//   FIFO pointers wrap modulo BUF_DEPTH; full = buf_count==BUF_DEPTH.
//     buf_count never exceeds BUF_DEPTH and never underflows.
//   Stable-hold rule: while inst_valid=1 and inst_ready=0, inst/inst_pc stay stable
//     unless a redirect occurs.
// TESTING
//   1 Reset release, RESET_PC=0, inst_ready=1, mem[0..3]=A,B,C,D
//     -> imem_addr 0,4,8,...; inst_valid high from cycle 1; inst_pc 0,4,8; inst A,B,C.
//   2 inst_ready=0 for 5 cycles -> buf_count 1,2,2,2; imem_addr frozen at 8;
//     after inst_ready=1: A,B,C in order, no loss or duplicates.
//   3 FIFO full + inst_ready=1 -> same-cycle pop and push; buf_count stays 2;
//     imem_addr advances by 4 each cycle.
//   4 redirect_valid=1, redirect_pc=0x47 during streaming -> next cycle buf_count=0,
//     imem_addr=0x44; next inst_pc=0x44; no pre-redirect instruction appears after.
//   5 redirect_valid and pop in the same cycle with FIFO full -> FIFO empty afterward;
//     imem_addr=target.
//   6 RESET_PC=0xFFFFFFF8 -> inst_pc FFFFFFF8, FFFFFFFC, 00000000.
//     rst pulsed low mid-stream -> outputs reset immediately, asynchronously.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction fetch front end
//
// Holds the program counter and drives word-aligned addresses to a
// combinational instruction memory. Each returned word is stored in a small
// FIFO together with the address it came from. Decode drains the FIFO through
// a valid/ready handshake. A redirect from branch/jump resolution reloads the
// PC and empties the FIFO in the same edge.
//
// Parameters
//   RESET_PC        PC loaded on reset (low two bits forced to zero)
//   BUF_DEPTH       FIFO entries, power of two, at least 2
//
// Ports
//   clk             in   1    clock, rising edge
//   rst             in   1    asynchronous reset, active low
//   imem_addr       out  32   fetch byte address, always word aligned
//   imem_data       in   32   instruction word for imem_addr, same cycle
//   redirect_valid  in   1    redirect request
//   redirect_pc     in   32   redirect target byte address
//   inst_valid      out  1    FIFO head holds an instruction
//   inst            out  32   FIFO head instruction word
//   inst_pc         out  32   byte address of the head instruction
//   inst_ready      in   1    decode accepts the head this cycle
//   buf_count       out  CW   FIFO occupancy, CW = $clog2(BUF_DEPTH)+1
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [31:0]                  imem_addr,
    input  logic [31:0]                  imem_data,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         inst_valid,
    output logic [31:0]                  inst,
    output logic [31:0]                  inst_pc,
    input  logic                         inst_ready,
    output logic [$clog2(BUF_DEPTH):0]   buf_count
);

    localparam int                PTR_W   = $clog2(BUF_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [31:0]       PC_RST  = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]       r_pc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_hold_inst;
    logic [31:0]       r_hold_pc;
    logic [31:0]       r_buf_inst [BUF_DEPTH];
    logic [31:0]       r_buf_pc   [BUF_DEPTH];

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic [31:0]       w_head_inst;
    logic [31:0]       w_head_pc;

    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid & inst_ready;
    // A full FIFO may still fetch when the head leaves in the same cycle,
    // which keeps a one-per-cycle stream free of bubbles.
    assign w_push      = ~redirect_valid & ((r_count < DEPTH_C) | w_pop);
    assign w_head_inst = r_buf_inst[r_rd_ptr];
    assign w_head_pc   = r_buf_pc[r_rd_ptr];

    // Control state: PC, pointers, occupancy, and the last-shown head copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc        <= PC_RST;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_hold_inst <= '0;
            r_hold_pc   <= '0;
        end else begin
            // Remember what decode currently sees so the outputs can hold it
            // once the FIFO drains or is flushed.
            if (w_valid) begin
                r_hold_inst <= w_head_inst;
                r_hold_pc   <= w_head_pc;
            end
            if (redirect_valid) begin
                r_pc     <= redirect_pc & 32'hFFFF_FFFC;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_pc     <= r_pc + 32'd4;
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage is pure data and needs no reset: entries are only read
    // while the occupancy says they were written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_inst[r_wr_ptr] <= imem_data;
            r_buf_pc[r_wr_ptr]   <= r_pc;
        end
    end

    assign imem_addr  = r_pc;
    assign inst_valid = w_valid;
    assign inst       = w_valid ? w_head_inst : r_hold_inst;
    assign inst_pc    = w_valid ? w_head_pc   : r_hold_pc;
    assign buf_count  = r_count;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch
//
// dut0 (RESET_PC=0) is driven through reset, stalls, full-FIFO streaming,
// redirects and an asynchronous reset. dut1 (RESET_PC=0xFFFFFFF8) streams
// continuously to show PC wrap-around. A queue-based model predicts dut0 and
// is compared every falling edge; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] imem_addr0, imem_data0, inst0, inst_pc0;
    logic        inst_valid0;
    logic [1:0]  buf_count0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic [31:0] imem_addr1, imem_data1, inst1, inst_pc1;
    logic        inst_valid1;
    logic [1:0]  buf_count1;

    int checks   = 0;
    int failures = 0;

    // Model state
    ent_t        q[$];
    logic [31:0] m_pc;
    ent_t        m_last;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h1111_1111;
            32'h4:   return 32'h2222_2222;
            32'h8:   return 32'h3333_3333;
            32'hC:   return 32'h4444_4444;
            default: return {a[15:0] ^ 16'hBEEF, a[31:16]};
        endcase
    endfunction

    assign imem_data0 = mem_word(imem_addr0);
    assign imem_data1 = mem_word(imem_addr1);

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut0 (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr0),
        .imem_data      (imem_data0),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid0),
        .inst           (inst0),
        .inst_pc        (inst_pc0),
        .inst_ready     (inst_ready),
        .buf_count      (buf_count0)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(DEPTH)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr1),
        .imem_data      (imem_data1),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .inst_valid     (inst_valid1),
        .inst           (inst1),
        .inst_pc        (inst_pc1),
        .inst_ready     (1'b1),
        .buf_count      (buf_count1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: a queue of (pc, word) pairs and a PC counter.
    initial begin
        m_pc   = 32'h0;
        m_last = '0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                m_pc   = 32'h0;
                m_last = '0;
            end else if (redirect_valid) begin
                q.delete();
                m_pc = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                ent_t e;
                if (q.size() != 0 && inst_ready) void'(q.pop_front());
                if (q.size() < DEPTH) begin
                    e.pc   = m_pc;
                    e.word = mem_word(m_pc);
                    q.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Compare process: dut0 against the model on every falling edge.
    always @(negedge clk) begin
        check("cmp_addr",  imem_addr0, m_pc);
        check("cmp_valid", 32'(inst_valid0), (q.size() != 0) ? 32'd1 : 32'd0);
        check("cmp_count", 32'(buf_count0), 32'(q.size()));
        if (q.size() != 0) begin
            check("cmp_inst",    inst0,    q[0].word);
            check("cmp_inst_pc", inst_pc0, q[0].pc);
            m_last = q[0];
        end else begin
            check("cmp_hold_inst", inst0,    m_last.word);
            check("cmp_hold_pc",   inst_pc0, m_last.pc);
        end
    end

    task automatic lit_head(input string tag, input logic [31:0] w, input logic [31:0] pc,
                            input logic [31:0] addr, input logic [31:0] cnt);
        check({tag, "_valid"}, 32'(inst_valid0), 32'd1);
        check({tag, "_inst"},  inst0,            w);
        check({tag, "_pc"},    inst_pc0,         pc);
        check({tag, "_addr"},  imem_addr0,       addr);
        check({tag, "_count"}, 32'(buf_count0),  cnt);
    endtask

    initial begin
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(inst_valid0), 32'd0);
        check("rst_count", 32'(buf_count0),  32'd0);
        check("rst_inst",  inst0,            32'd0);
        check("rst_pc",    inst_pc0,         32'd0);
        check("rst_addr",  imem_addr0,       32'd0);
        check("rst_addr1", imem_addr1,       32'hFFFF_FFF8);
        #1 rst = 1'b1;

        // Test 1 + wrap on dut1
        @(negedge clk);
        lit_head("t1_c1", 32'h1111_1111, 32'h0, 32'h4, 32'd1);
        check("t6_wrap_c1", inst_pc1, 32'hFFFF_FFF8);
        @(negedge clk);
        lit_head("t1_c2", 32'h2222_2222, 32'h4, 32'h8, 32'd1);
        check("t6_wrap_c2", inst_pc1, 32'hFFFF_FFFC);
        @(negedge clk);
        lit_head("t1_c3", 32'h3333_3333, 32'h8, 32'hC, 32'd1);
        check("t6_wrap_c3", inst_pc1, 32'h0000_0000);

        // Test 2: fresh reset, decode stalled for 5 cycles
        #1 rst = 1'b0; inst_ready = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        lit_head("t2_s1", 32'h1111_1111, 32'h0, 32'h4, 32'd1);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            lit_head($sformatf("t2_s%0d", i), 32'h1111_1111, 32'h0, 32'h8, 32'd2);
        end
        #1 inst_ready = 1'b1;

        // Test 3: full FIFO pops and pushes in the same cycle
        @(negedge clk);
        lit_head("t3_c1", 32'h2222_2222, 32'h4, 32'hC, 32'd2);
        @(negedge clk);
        lit_head("t3_c2", 32'h3333_3333, 32'h8, 32'h10, 32'd2);
        @(negedge clk);
        lit_head("t3_c3", 32'h4444_4444, 32'hC, 32'h14, 32'd2);

        // Test 4: redirect to 0x47 during streaming
        #1 redirect_valid = 1'b1; redirect_pc = 32'h47;
        @(negedge clk);
        check("t4_valid", 32'(inst_valid0), 32'd0);
        check("t4_count", 32'(buf_count0),  32'd0);
        check("t4_addr",  imem_addr0,       32'h44);
        check("t4_hold",  inst0,            32'h4444_4444);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        lit_head("t4_n1", 32'hBEAB_0000, 32'h44, 32'h48, 32'd1);
        @(negedge clk);
        lit_head("t4_n2", 32'hBEA7_0000, 32'h48, 32'h4C, 32'd1);

        // Test 5: redirect together with a pop while full
        #1 inst_ready = 1'b0;
        @(negedge clk);
        lit_head("t5_full", 32'hBEA7_0000, 32'h48, 32'h50, 32'd2);
        #1 inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        check("t5_valid", 32'(inst_valid0), 32'd0);
        check("t5_count", 32'(buf_count0),  32'd0);
        check("t5_addr",  imem_addr0,       32'h100);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        lit_head("t5_n1", 32'hBFEF_0000, 32'h100, 32'h104, 32'd1);

        // Test 6: asynchronous reset mid-cycle
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_async_valid", 32'(inst_valid0), 32'd0);
        check("t6_async_count", 32'(buf_count0),  32'd0);
        check("t6_async_inst",  inst0,            32'd0);
        check("t6_async_pc",    inst_pc0,         32'd0);
        check("t6_async_addr",  imem_addr0,       32'd0);
        check("t6_async_addr1", imem_addr1,       32'hFFFF_FFF8);
        check("t6_async_vld1",  32'(inst_valid1), 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6_rerun_c1", inst_pc1, 32'hFFFF_FFF8);
        @(negedge clk);
        check("t6_rerun_c2", inst_pc1, 32'hFFFF_FFFC);
        @(negedge clk);
        check("t6_rerun_c3", inst_pc1, 32'h0000_0000);
        lit_head("t6_dut0", 32'h3333_3333, 32'h8, 32'hC, 32'd1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
